// File: rtl/multi_mode_register.sv
// multi_mode_register: datapath register with clear/load, step inc/dec and serial multi-bit shifts
module multi_mode_register #(
  parameter int DATA_WIDTH  = 16,
  parameter int STEP_WIDTH  = 4,
  parameter int SHAMT_WIDTH = 4,
  parameter int SATURATE    = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cl,
  input  logic                   ld,
  input  logic [DATA_WIDTH-1:0]  in,
  input  logic                   inc,
  input  logic                   dec,
  input  logic [STEP_WIDTH-1:0]  step,
  input  logic                   sr,
  input  logic                   sl,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  input  logic                   rot,
  input  logic                   arith,
  input  logic                   ir,
  input  logic                   il,
  output logic [DATA_WIDTH-1:0]  out,
  output logic                   carry,
  output logic                   zero,
  output logic                   busy,
  output logic                   done
);
  typedef enum logic {IDLE, SHIFT} state_e;
  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  out_q, out_d;
  logic                   carry_q, carry_d, done_q, done_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   left_q, left_d, rot_q, rot_d, arith_q, arith_d, fill_q, fill_d;
  logic [DATA_WIDTH:0]    sum, diff;
  logic [DATA_WIDTH-1:0]  step_x, sh_val;
  logic                   sh_left, sh_rot, sh_arith, sh_fill, sh_in, sh_co;
  assign step_x   = {{(DATA_WIDTH-STEP_WIDTH){1'b0}}, step};
  assign sum      = {1'b0, out_q} + {1'b0, step_x};
  assign diff     = {1'b0, out_q} - {1'b0, step_x};
  // The first bit of a shift uses the live mode inputs; later bits use the latched copy.
  assign sh_left  = (state_q == SHIFT) ? left_q  : !sr;
  assign sh_rot   = (state_q == SHIFT) ? rot_q   : rot;
  assign sh_arith = (state_q == SHIFT) ? arith_q : arith;
  assign sh_fill  = (state_q == SHIFT) ? fill_q  : (sr ? ir : il);
  assign sh_in    = sh_left ? (sh_rot ? out_q[DATA_WIDTH-1] : sh_fill)
                            : (sh_rot ? out_q[0] : sh_arith ? out_q[DATA_WIDTH-1] : sh_fill);
  assign sh_val   = sh_left ? {out_q[DATA_WIDTH-2:0], sh_in} : {sh_in, out_q[DATA_WIDTH-1:1]};
  assign sh_co    = sh_left ? out_q[DATA_WIDTH-1] : out_q[0];
  // Command decode and shift sequencing; cnt_q holds bits still to apply while in SHIFT.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    left_d  = left_q;
    rot_d   = rot_q;
    arith_d = arith_q;
    fill_d  = fill_q;
    if (cl) begin
      out_d   = '0;
      carry_d = 1'b0;
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      out_d   = sh_val;
      carry_d = sh_co;
      cnt_d   = cnt_q - SHAMT_WIDTH'(1);
      if (cnt_q == SHAMT_WIDTH'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (ld) begin
      out_d = in;
    end else if (inc) begin
      carry_d = sum[DATA_WIDTH];
      out_d   = (SATURATE != 0 && sum[DATA_WIDTH]) ? '1 : sum[DATA_WIDTH-1:0];
    end else if (dec) begin
      carry_d = diff[DATA_WIDTH];
      out_d   = (SATURATE != 0 && diff[DATA_WIDTH]) ? '0 : diff[DATA_WIDTH-1:0];
    end else if (sr || sl) begin
      left_d  = !sr;
      rot_d   = rot;
      arith_d = arith;
      fill_d  = sr ? ir : il;
      done_d  = shamt <= SHAMT_WIDTH'(1);
      if (shamt != '0) begin
        out_d   = sh_val;
        carry_d = sh_co;
      end
      if (shamt > SHAMT_WIDTH'(1)) begin
        state_d = SHIFT;
        cnt_d   = shamt - SHAMT_WIDTH'(1);
      end
    end
  end
  // State register with asynchronous clear of value, flags, counter and latched mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      rot_q   <= 1'b0;
      arith_q <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      rot_q   <= rot_d;
      arith_q <= arith_d;
      fill_q  <= fill_d;
    end
  end
  assign out   = out_q;
  assign carry = carry_q;
  assign zero  = (out_q == '0);
  assign busy  = (state_q == SHIFT);
  assign done  = done_q;
endmodule

// File: tb/tb_multi_mode_register.sv
// tb_multi_mode_register: checks wrap and saturate instances against a behavioural model
module tb_multi_mode_register;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cl = 0, ld = 0, inc = 0, dec = 0, sr = 0, sl = 0, rot = 0, arith = 0, ir = 0, il = 0;
  logic [15:0] din = '0;
  logic [3:0]  step = '0, shamt = '0;
  logic [15:0] out_w [2];
  logic        carry_w [2], zero_w [2], busy_w [2], done_w [2];
  int          n_cmp = 0, n_bad = 0;
  logic [15:0] m_out [2];
  logic        m_carry [2];
  logic        m_done;
  int          m_rem;
  logic        m_left, m_rot, m_arith, m_fill;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    multi_mode_register #(.DATA_WIDTH(16), .STEP_WIDTH(4), .SHAMT_WIDTH(4), .SATURATE(g)) u_dut (
      .clk(clk), .rst_n(rst_n), .cl(cl), .ld(ld), .in(din), .inc(inc), .dec(dec), .step(step),
      .sr(sr), .sl(sl), .shamt(shamt), .rot(rot), .arith(arith), .ir(ir), .il(il),
      .out(out_w[g]), .carry(carry_w[g]), .zero(zero_w[g]), .busy(busy_w[g]), .done(done_w[g]));
  end

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_out[s]   = '0;
      m_carry[s] = 1'b0;
    end
    m_done = 1'b0;
    m_rem  = 0;
  endtask

  task automatic shift_bit(input int s, input logic left, input logic r, input logic a, input logic f);
    logic [15:0] v;
    logic fb;
    v = m_out[s];
    if (left) begin
      fb = r ? v[15] : f;
      m_carry[s] = v[15];
      m_out[s] = (v << 1) | 16'(fb);
    end else begin
      fb = r ? v[0] : (a ? v[15] : f);
      m_carry[s] = v[0];
      m_out[s] = (v >> 1) | (16'(fb) << 15);
    end
  endtask

  task automatic model_edge();
    int t;
    for (int s = 0; s < 2; s++) begin
      if (cl) begin
        m_out[s] = '0;
        m_carry[s] = 1'b0;
      end else if (m_rem > 0) begin
        shift_bit(s, m_left, m_rot, m_arith, m_fill);
      end else if (ld) begin
        m_out[s] = din;
      end else if (inc) begin
        t = int'(m_out[s]) + int'(step);
        m_carry[s] = t > 65535;
        m_out[s] = (s == 1 && m_carry[s]) ? 16'hFFFF : 16'(t);
      end else if (dec) begin
        m_carry[s] = {12'h0, step} > m_out[s];
        m_out[s] = (s == 1 && m_carry[s]) ? 16'h0 : 16'(m_out[s] - {12'h0, step});
      end else if ((sr || sl) && shamt != 0) begin
        shift_bit(s, !sr, rot, arith, sr ? ir : il);
      end
    end
    if (cl) begin
      m_rem = 0;
      m_done = 1'b0;
    end else if (m_rem > 0) begin
      m_rem--;
      m_done = (m_rem == 0);
    end else if (!ld && !inc && !dec && (sr || sl)) begin
      m_left = !sr;
      m_rot = rot;
      m_arith = arith;
      m_fill = sr ? ir : il;
      m_rem = (shamt == 0) ? 0 : int'(shamt) - 1;
      m_done = (shamt <= 1);
    end else begin
      m_done = 1'b0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cmds();
    {cl, ld, inc, dec, sr, sl, rot, arith, ir, il} = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if ({out_w[s], carry_w[s], busy_w[s], done_w[s], zero_w[s]} !== {16'h0, 4'b0001}) begin
        n_bad++;
        $display("FAIL reset[%0d]: out=%h c=%b b=%b d=%b z=%b, want 0000 0 0 0 1", s, out_w[s], carry_w[s], busy_w[s], done_w[s], zero_w[s]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sl_one();
    clear_cmds(); ld = 1; din = 16'h8001; tick();
    clear_cmds(); sl = 1; shamt = 1; tick();
    clear_cmds();
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if ({out_w[s], carry_w[s], busy_w[s], done_w[s]} !== {16'h0002, 3'b101}) begin
        n_bad++;
        $display("FAIL sl_one[%0d]: out=%h c=%b b=%b d=%b, want 0002 1 0 1", s, out_w[s], carry_w[s], busy_w[s], done_w[s]);
      end
    end
    tick();
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if ({busy_w[s], done_w[s]} !== 2'b00) begin
        n_bad++;
        $display("FAIL sl_one_after[%0d]: b=%b d=%b, want 0 0", s, busy_w[s], done_w[s]);
      end
    end
  endtask

  task automatic test_arith_sr();
    logic [15:0] e [4];
    e = '{16'hC000, 16'hE000, 16'hF000, 16'hF800};
    clear_cmds(); ld = 1; din = 16'h8000; tick();
    clear_cmds(); sr = 1; arith = 1; shamt = 4;
    for (int i = 0; i < 4; i++) begin
      tick();
      clear_cmds();
      for (int s = 0; s < 2; s++) begin
        n_cmp++;
        if ({out_w[s], carry_w[s], busy_w[s], done_w[s]} !== {e[i], 1'b0, i < 3, i == 3}) begin
          n_bad++;
          $display("FAIL arith_sr[%0d] step %0d: out=%h c=%b b=%b d=%b, want %h 0 %b %b", s, i, out_w[s], carry_w[s], busy_w[s], done_w[s], e[i], i < 3, i == 3);
        end
      end
    end
    tick();
    n_cmp++;
    if (done_w[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL arith_sr_single_done: done=%b, want 0", done_w[0]);
    end
  endtask

  task automatic test_rotate();
    int busy_cnt = 0;
    clear_cmds(); ld = 1; din = 16'h1234; tick();
    clear_cmds(); sr = 1; rot = 1; shamt = 8; tick();
    if (busy_w[0]) busy_cnt++;
    for (int i = 1; i < 8; i++) begin
      {ld, inc, dec, sr, sl, rot, arith, ir, il} = 9'($urandom);
      din = 16'($urandom); step = 4'($urandom); shamt = 4'($urandom);
      tick();
      if (busy_w[0]) busy_cnt++;
    end
    clear_cmds();
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if ({out_w[s], carry_w[s], busy_w[s], done_w[s]} !== {16'h3412, 3'b001}) begin
        n_bad++;
        $display("FAIL rotate[%0d]: out=%h c=%b b=%b d=%b, want 3412 0 0 1", s, out_w[s], carry_w[s], busy_w[s], done_w[s]);
      end
    end
    n_cmp++;
    if (busy_cnt != 7) begin
      n_bad++;
      $display("FAIL rotate_busy_cycles: got %0d, want 7", busy_cnt);
    end
  endtask

  task automatic test_saturate();
    clear_cmds(); ld = 1; din = 16'hFFFE; tick();
    clear_cmds(); inc = 1; step = 3; tick();
    n_cmp++;
    if ({out_w[0], carry_w[0], out_w[1], carry_w[1]} !== {16'h0001, 1'b1, 16'hFFFF, 1'b1}) begin
      n_bad++;
      $display("FAIL inc_overflow: wrap=%h/%b sat=%h/%b, want 0001/1 ffff/1", out_w[0], carry_w[0], out_w[1], carry_w[1]);
    end
    clear_cmds(); inc = 1; step = 0; tick();
    n_cmp++;
    if ({out_w[0], carry_w[0], out_w[1], carry_w[1]} !== {16'h0001, 1'b0, 16'hFFFF, 1'b0}) begin
      n_bad++;
      $display("FAIL inc_step0: wrap=%h/%b sat=%h/%b, want 0001/0 ffff/0", out_w[0], carry_w[0], out_w[1], carry_w[1]);
    end
    clear_cmds(); ld = 1; din = 16'h0002; tick();
    clear_cmds(); dec = 1; step = 5; tick();
    clear_cmds();
    n_cmp++;
    if ({out_w[0], carry_w[0], out_w[1], carry_w[1], zero_w[1]} !== {16'hFFFD, 1'b1, 16'h0000, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL dec_borrow: wrap=%h/%b sat=%h/%b z=%b, want fffd/1 0000/1 z=1", out_w[0], carry_w[0], out_w[1], carry_w[1], zero_w[1]);
    end
  endtask

  task automatic test_abort_priority();
    clear_cmds(); ld = 1; din = 16'h00F3; tick();
    clear_cmds(); sl = 1; shamt = 10; tick();
    clear_cmds(); tick(); tick();
    cl = 1; tick();
    cl = 0;
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if ({out_w[s], carry_w[s], busy_w[s], done_w[s], zero_w[s]} !== {16'h0, 4'b0001}) begin
        n_bad++;
        $display("FAIL abort[%0d]: out=%h c=%b b=%b d=%b z=%b, want 0000 0 0 0 1", s, out_w[s], carry_w[s], busy_w[s], done_w[s], zero_w[s]);
      end
    end
    tick();
    n_cmp++;
    if ({busy_w[0], done_w[0]} !== 2'b00) begin
      n_bad++;
      $display("FAIL abort_no_done: b=%b d=%b, want 0 0", busy_w[0], done_w[0]);
    end
    cl = 1; ld = 1; din = 16'hABCD; tick();
    clear_cmds();
    n_cmp++;
    if (out_w[0] !== 16'h0) begin
      n_bad++;
      $display("FAIL cl_over_ld: out=%h, want 0000", out_w[0]);
    end
    ld = 1; inc = 1; din = 16'h1111; step = 5; tick();
    clear_cmds();
    n_cmp++;
    if (out_w[0] !== 16'h1111) begin
      n_bad++;
      $display("FAIL ld_over_inc: out=%h, want 1111", out_w[0]);
    end
  endtask

  task automatic test_async_reset();
    clear_cmds(); ld = 1; din = 16'h5A5A; tick();
    clear_cmds(); sr = 1; shamt = 15; tick();
    clear_cmds(); tick();
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if ({out_w[s], carry_w[s], busy_w[s], done_w[s], zero_w[s]} !== {16'h0, 4'b0001}) begin
        n_bad++;
        $display("FAIL async_reset[%0d]: out=%h c=%b b=%b d=%b z=%b, want 0000 0 0 0 1", s, out_w[s], carry_w[s], busy_w[s], done_w[s], zero_w[s]);
      end
    end
    #1 rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({out_w[0], busy_w[0], done_w[0]} !== {16'h0, 2'b00}) begin
      n_bad++;
      $display("FAIL async_reset_hold: out=%h b=%b d=%b, want 0000 0 0", out_w[0], busy_w[0], done_w[0]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cl = ($urandom_range(0, 24) == 0);
      ld = ($urandom_range(0, 5) == 0);
      inc = ($urandom_range(0, 3) == 0);
      dec = ($urandom_range(0, 3) == 0);
      sr = ($urandom_range(0, 2) == 0);
      sl = ($urandom_range(0, 2) == 0);
      {rot, arith, ir, il} = 4'($urandom);
      din = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom);
      step = 4'($urandom);
      shamt = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom);
      tick();
      for (int s = 0; s < 2; s++) begin
        n_cmp++;
        if (out_w[s] !== m_out[s] || carry_w[s] !== m_carry[s] || busy_w[s] !== (m_rem > 0) ||
            done_w[s] !== m_done || zero_w[s] !== (m_out[s] == 16'h0)) begin
          n_bad++;
          $display("FAIL random[%0d] cyc %0d: out=%h c=%b b=%b d=%b z=%b, want %h %b %b %b %b", s, i,
                   out_w[s], carry_w[s], busy_w[s], done_w[s], zero_w[s],
                   m_out[s], m_carry[s], m_rem > 0, m_done, m_out[s] == 16'h0);
        end
      end
    end
    clear_cmds();
  endtask

  initial begin
    model_reset();
    m_left = 0; m_rot = 0; m_arith = 0; m_fill = 0;
    test_reset();
    test_sl_one();
    test_arith_sr();
    test_rotate();
    test_saturate();
    test_abort_priority();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
